maq_bcd_cont: RTL and testbench
===============================

# maq_bcd_cont

Parametrised two-digit BCD modulo counter for the digital-clock datapath. One instance covers any clock field: seconds and minutes (00–59), 24-hour hours (00–23), and 12-hour hours (01–12). It adds a synchronous preset for time setting, an optional down-count direction, a terminal-count flag for cascading and a registered wrap pulse. Instances chain seconds → minutes → hours by gating each stage's increment with the previous stage's terminal count.

## Interface
- MSD_W, 3: width of the most-significant digit (3 for minutes/seconds, 2 for hours).
- MIN_VAL, 0: lowest count value as an integer, 0..98 (1 for 12-hour mode).
- MAX_VAL, 59: highest count value as an integer, MIN_VAL+1..99.
- RESET_VAL, 59: value after reset; must lie in MIN_VAL..MAX_VAL.

Ports (maqb_clock and maqb_reset first):
- maqb_clock  in  1  system clock.
- maqb_reset  in  1  asynchronous, active-low reset.
- maqb_enable  in  1  block enable; when low, counting is frozen.
- maqb_incremento  in  1  count tick, a one-cycle pulse.
- maqb_dir  in  1  direction: 0 = up, 1 = down. Only honoured with MAQB_DOWN_EN (see Configuration).
- maqb_load  in  1  synchronous preset strobe.
- maqb_load_lsd  in  4  preset value, least-significant digit (BCD).
- maqb_load_msd  in  MSD_W  preset value, most-significant digit (BCD).
- maqb_Lsd  out  4  count value, least-significant digit.
- maqb_Msd  out  MSD_W  count value, most-significant digit.
- maqb_tc  out  1  terminal-count flag; chain into the next stage as next.incremento = incremento & tc.
- maqb_wrap  out  1  registered one-cycle pulse, asserted the cycle after a wrap.

## Operation
- Value V = 10·Msd + Lsd. V always lies in MIN_VAL..MAX_VAL; Lsd is always 0..9.
- Priority, evaluated per clock edge: reset > load > count > hold.
- Load: when maqb_load=1, V takes the preset value. This happens regardless of enable.
  - Preset above MAX_VAL, or Lsd > 9: V saturates to MAX_VAL.
  - Preset below MIN_VAL: V saturates to MIN_VAL.
  - wrap stays 0 on a load.
- Count up: on enable & incremento & !load, with dir=0.
  - V=MAX_VAL: V goes to MIN_VAL and wrap is asserted.
  - Lsd=9: Lsd goes to 0 and Msd increments.
  - Otherwise Lsd increments.
- Count down: on enable & incremento & !load, with dir=1.
  - V=MIN_VAL: V goes to MAX_VAL and wrap is asserted.
  - Lsd=0: Lsd goes to 9 and Msd decrements.
  - Otherwise Lsd decrements.
- maqb_tc is decoded from the registers and dir only: (dir=0 & V=MAX_VAL) | (dir=1 & V=MIN_VAL). It never depends on incremento.
- incremento while enable=0: ignored, and wrap stays 0.
- dir may change between ticks. tc follows dir in the same cycle.
- All internal arithmetic is done in BCD. No binary-to-BCD conversion exists in the datapath.

## Timing
- Reset values: Lsd = RESET_VAL mod 10, Msd = RESET_VAL / 10, wrap = 0. tc is decoded from the reset value.
- Reset asserted mid-count or mid-load overrides everything in the same instant, because it is asynchronous.
- Latency: a count or load takes effect on Lsd/Msd one clock after the qualifying edge.
- wrap is high for exactly one cycle, aligned with the wrapped value.
- tc is valid in the same cycle as V. A cascaded stage therefore advances on the same edge as the stage that wraps: zero-cycle carry chain.
- Back-to-back incremento pulses are legal, one count per cycle.

## Configuration
- MAQB_DOWN_EN defined: maqb_dir is honoured, and the down-count and borrow logic is built.
- MAQB_DOWN_EN undefined:
  - maqb_dir is ignored and the block counts up only.
  - tc = (V=MAX_VAL).
  - The down-count logic is not synthesised.
  - The port still exists, so the port list is identical in both builds.

## Structure
- Shared package maq_pkg holds:
  - typedef bcd_digit_t (logic [3:0]).
  - constants BCD_MAX=9 and BCD_MIN=0.
  - function bcd_to_int, used in the tc/limit compare and in assertions.
- Sub-module maq_bcd_digit: one BCD digit with up/down step, carry/borrow in and out, and a parametrised max value.
  - One instance for Lsd (max 9).
  - One instance for Msd (max derived from MAX_VAL).
  - The top level applies the MIN_VAL/MAX_VAL wrap and the load saturation.

## Test plan
- Defaults: reset → V=59, tc=1. One tick → V=00, wrap=1 for 1 cycle, tc=0. Ten ticks → V=10.
- Hours (MSD_W=2, MAX_VAL=23, RESET_VAL=0): 24 ticks → sequence 00..23 then 00, with wrap only on 23→00.
- 12-hour (MIN_VAL=1, MAX_VAL=12, RESET_VAL=12): tick → 01. Load 15 → 12. Load 00 → 01.
- Load 47 with incremento=1 in the same cycle → V=47 with no increment. enable=0 with 5 ticks → V unchanged.
- MAQB_DOWN_EN, dir=1, V=00 (MAX_VAL=59): tick → 59 and wrap=1. From V=10: tick → 09. tc=1 only at 00.
- Cascade of two instances (seconds, then minutes, with minutes.incremento = tick & seconds.tc) from 59:59: tick → 00:00 on the same edge. Reset mid-sequence → 59:59 immediately.

Source files
------------

// File: rtl/maq_pkg.sv
// maq_pkg: BCD digit type, digit limits and the BCD-to-integer helper
// shared by the maq_bcd_cont clock-field counter and its digit cells.
package maq_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Decimal weight of a two-digit BCD pair; only feeds comparators, never the datapath.
    function automatic int bcd_to_int(input bcd_digit_t msd, input bcd_digit_t lsd);
        return 10 * int'(msd) + int'(lsd);
    endfunction

endpackage

// File: rtl/maq_bcd_digit.sv
// maq_bcd_digit: one BCD digit register with step, carry/borrow out and preset.
// The borrow path exists only when MAQB_DOWN_EN is defined.
module maq_bcd_digit
    import maq_pkg::*;
#(
    parameter int W       = 4,
    parameter int MAX_D   = 9,
    parameter int RESET_D = 0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         step_i,
    input  logic         down_i,
    output logic [W-1:0] q_o,
    output logic         carry_o
);

    localparam logic [W-1:0] TOP    = W'(MAX_D);
    localparam logic [W-1:0] BOTTOM = W'(BCD_MIN);
    localparam logic [W-1:0] ONE    = W'(1);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         downEff;
    logic         atEdge;

`ifdef MAQB_DOWN_EN
    assign downEff = down_i;
`else
    logic unusedDown;
    assign unusedDown = down_i;
    assign downEff    = 1'b0;
`endif

    // The digit rolls over when it sits at the end of its range in the step direction.
    assign atEdge  = downEff ? (q_q == BOTTOM) : (q_q == TOP);
    assign carry_o = step_i & atEdge;

    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = ld_val_i;
        end else if (step_i) begin
            if (atEdge) begin
                q_d = downEff ? TOP : BOTTOM;
            end else begin
                q_d = downEff ? (q_q - ONE) : (q_q + ONE);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_q <= W'(RESET_D);
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/maq_bcd_cont.sv
// maq_bcd_cont: two-digit BCD modulo counter for one digital-clock field.
// Define MAQB_DOWN_EN to honour maqb_dir and build the down-count path.
module maq_bcd_cont
    import maq_pkg::*;
#(
    parameter int MSD_W     = 3,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 59,
    parameter int RESET_VAL = 59
) (
    input  logic             maqb_clock,
    input  logic             maqb_reset,
    input  logic             maqb_enable,
    input  logic             maqb_incremento,
    input  logic             maqb_dir,
    input  logic             maqb_load,
    input  logic [3:0]       maqb_load_lsd,
    input  logic [MSD_W-1:0] maqb_load_msd,
    output logic [3:0]       maqb_Lsd,
    output logic [MSD_W-1:0] maqb_Msd,
    output logic             maqb_tc,
    output logic             maqb_wrap
);

    localparam bcd_digit_t       MIN_LSD = bcd_digit_t'(MIN_VAL % 10);
    localparam logic [MSD_W-1:0] MIN_MSD = MSD_W'(MIN_VAL / 10);
    localparam bcd_digit_t       MAX_LSD = bcd_digit_t'(MAX_VAL % 10);
    localparam logic [MSD_W-1:0] MAX_MSD = MSD_W'(MAX_VAL / 10);

    bcd_digit_t       curLsd;
    logic [MSD_W-1:0] curMsd;
    bcd_digit_t       msdWide;
    bcd_digit_t       loadMsdWide;
    int               curVal;
    int               presetVal;
    logic             downEff;
    logic             atMax;
    logic             atMin;
    logic             countEn;
    logic             digitLd;
    logic             lsdStep;
    logic             lsdCarry;
    bcd_digit_t       ldLsd;
    logic [MSD_W-1:0] ldMsd;
    logic             wrap_q;
    logic             wrap_d;
    logic             unusedMsdCarry;

`ifdef MAQB_DOWN_EN
    assign downEff = maqb_dir;
`else
    logic unusedDir;
    assign unusedDir = maqb_dir;
    assign downEff   = 1'b0;
`endif

    always_comb begin
        msdWide                  = '0;
        msdWide[MSD_W-1:0]       = curMsd;
        loadMsdWide              = '0;
        loadMsdWide[MSD_W-1:0]   = maqb_load_msd;
    end

    assign curVal    = bcd_to_int(msdWide, curLsd);
    assign presetVal = bcd_to_int(loadMsdWide, maqb_load_lsd);
    assign atMax     = (curVal == MAX_VAL);
    assign atMin     = (curVal == MIN_VAL);
    assign maqb_tc   = downEff ? atMin : atMax;

    // A field wrap is a forced preset of the opposite limit, so it shares the load path.
    assign countEn = maqb_enable & maqb_incremento & ~maqb_load;
    assign wrap_d  = countEn & maqb_tc;
    assign digitLd = maqb_load | wrap_d;
    assign lsdStep = countEn & ~maqb_tc;

    always_comb begin
        ldLsd = MIN_LSD;
        ldMsd = MIN_MSD;
        if (maqb_load) begin
            if ((maqb_load_lsd > BCD_MAX) || (presetVal > MAX_VAL)) begin
                ldLsd = MAX_LSD;
                ldMsd = MAX_MSD;
            end else if (presetVal < MIN_VAL) begin
                ldLsd = MIN_LSD;
                ldMsd = MIN_MSD;
            end else begin
                ldLsd = maqb_load_lsd;
                ldMsd = maqb_load_msd;
            end
        end else if (downEff) begin
            ldLsd = MAX_LSD;
            ldMsd = MAX_MSD;
        end
    end

    maq_bcd_digit #(
        .W       (4),
        .MAX_D   (9),
        .RESET_D (RESET_VAL % 10)
    ) u_lsd (
        .clk_i    (maqb_clock),
        .rst_n_i  (maqb_reset),
        .ld_i     (digitLd),
        .ld_val_i (ldLsd),
        .step_i   (lsdStep),
        .down_i   (downEff),
        .q_o      (curLsd),
        .carry_o  (lsdCarry)
    );

    maq_bcd_digit #(
        .W       (MSD_W),
        .MAX_D   (MAX_VAL / 10),
        .RESET_D (RESET_VAL / 10)
    ) u_msd (
        .clk_i    (maqb_clock),
        .rst_n_i  (maqb_reset),
        .ld_i     (digitLd),
        .ld_val_i (ldMsd),
        .step_i   (lsdCarry),
        .down_i   (downEff),
        .q_o      (curMsd),
        .carry_o  (unusedMsdCarry)
    );

    always_ff @(posedge maqb_clock or negedge maqb_reset) begin
        if (!maqb_reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign maqb_Lsd  = curLsd;
    assign maqb_Msd  = curMsd;
    assign maqb_wrap = wrap_q;

    // The count must never leave its field and the low digit must stay valid BCD.
    assert property (@(posedge maqb_clock) disable iff (!maqb_reset)
        (curLsd <= BCD_MAX) && (curVal >= MIN_VAL) && (curVal <= MAX_VAL));

endmodule

// File: tb/tb_maq_bcd_cont.sv
// tb_maq_bcd_cont: seconds/minutes cascade, 24-hour and 12-hour fields checked
// against an integer reference model, hand tables and corner-case sequences.
module tb_maq_bcd_cont;

`ifdef MAQB_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic rstN;

    logic       enA, incA, dirA, ldA, ldB;
    logic [3:0] ldLsdA, ldLsdB;
    logic [2:0] ldMsdA, ldMsdB;
    logic [3:0] secLsd, minLsd;
    logic [2:0] secMsd, minMsd;
    logic       secTc, secWrap, minTc, minWrap, minInc;

    logic       enH, incH, dirH, ldH;
    logic [3:0] ldLsdH, hrLsd;
    logic [1:0] ldMsdH, hrMsd;
    logic       hrTc, hrWrap;

    logic       enT, incT, dirT, ldT;
    logic [3:0] ldLsdT, tLsd;
    logic [1:0] ldMsdT, tMsd;
    logic       tTc, tWrap;

    int nAssert = 0;
    int nFail   = 0;
    int mSec, mMin, mHr, m12;

    typedef struct {
        bit en;
        bit inc;
        bit ld;
        int pMsd;
        int pLsd;
        int expV;
        bit expWrap;
        bit expTc;
    } vecT;

    vecT vecs[15];

    always #5 clock = ~clock;

    assign minInc = incA & secTc;

    maq_bcd_cont u_sec (
        .maqb_clock(clock), .maqb_reset(rstN), .maqb_enable(enA), .maqb_incremento(incA),
        .maqb_dir(dirA), .maqb_load(ldA), .maqb_load_lsd(ldLsdA), .maqb_load_msd(ldMsdA),
        .maqb_Lsd(secLsd), .maqb_Msd(secMsd), .maqb_tc(secTc), .maqb_wrap(secWrap));

    maq_bcd_cont u_min (
        .maqb_clock(clock), .maqb_reset(rstN), .maqb_enable(enA), .maqb_incremento(minInc),
        .maqb_dir(dirA), .maqb_load(ldB), .maqb_load_lsd(ldLsdB), .maqb_load_msd(ldMsdB),
        .maqb_Lsd(minLsd), .maqb_Msd(minMsd), .maqb_tc(minTc), .maqb_wrap(minWrap));

    maq_bcd_cont #(.MSD_W(2), .MIN_VAL(0), .MAX_VAL(23), .RESET_VAL(0)) u_hr (
        .maqb_clock(clock), .maqb_reset(rstN), .maqb_enable(enH), .maqb_incremento(incH),
        .maqb_dir(dirH), .maqb_load(ldH), .maqb_load_lsd(ldLsdH), .maqb_load_msd(ldMsdH),
        .maqb_Lsd(hrLsd), .maqb_Msd(hrMsd), .maqb_tc(hrTc), .maqb_wrap(hrWrap));

    maq_bcd_cont #(.MSD_W(2), .MIN_VAL(1), .MAX_VAL(12), .RESET_VAL(12)) u_h12 (
        .maqb_clock(clock), .maqb_reset(rstN), .maqb_enable(enT), .maqb_incremento(incT),
        .maqb_dir(dirT), .maqb_load(ldT), .maqb_load_lsd(ldLsdT), .maqb_load_msd(ldMsdT),
        .maqb_Lsd(tLsd), .maqb_Msd(tMsd), .maqb_tc(tTc), .maqb_wrap(tWrap));

    function automatic int toBcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic bit modelTc(input int v, input int lo, input int hi, input bit dir);
        return (DOWN_EN && dir) ? (v == lo) : (v == hi);
    endfunction

    // Field behaviour expressed as plain integer arithmetic on the decimal value.
    function automatic void modelStep(input int v, input int lo, input int hi, input bit en,
                                      input bit inc, input bit dir, input bit ld,
                                      input int pl, input int pm, output int vn, output bit wr);
        int p;
        p  = 10 * pm + pl;
        vn = v;
        wr = 1'b0;
        if (ld) begin
            if (pl > 9 || p > hi) vn = hi;
            else if (p < lo)      vn = lo;
            else                  vn = p;
        end else if (en && inc) begin
            if (DOWN_EN && dir) begin
                if (v == lo) begin vn = hi; wr = 1'b1; end
                else vn = v - 1;
            end else begin
                if (v == hi) begin vn = lo; wr = 1'b1; end
                else vn = v + 1;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nAssert++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic setIdle();
        enA = 1'b1; incA = 1'b0; dirA = 1'b0; ldA = 1'b0; ldB = 1'b0;
        ldLsdA = '0; ldMsdA = '0; ldLsdB = '0; ldMsdB = '0;
        enH = 1'b1; incH = 1'b0; dirH = 1'b0; ldH = 1'b0; ldLsdH = '0; ldMsdH = '0;
        enT = 1'b1; incT = 1'b0; dirT = 1'b0; ldT = 1'b0; ldLsdT = '0; ldMsdT = '0;
    endtask

    task automatic resetModel();
        mSec = 59; mMin = 59; mHr = 0; m12 = 12;
    endtask

    // Inputs are set just after a falling edge; one rising edge later all fields are checked.
    task automatic applyStimulus();
        int nSec, nMin, nHr, n12;
        bit wSec, wMin, wHr, w12, tSec;
        #1;
        tSec = modelTc(mSec, 0, 59, dirA);
        checkOutput("sec_tc", int'(secTc), int'(tSec));
        checkOutput("min_tc", int'(minTc), int'(modelTc(mMin, 0, 59, dirA)));
        checkOutput("hr_tc",  int'(hrTc),  int'(modelTc(mHr, 0, 23, dirH)));
        checkOutput("h12_tc", int'(tTc),   int'(modelTc(m12, 1, 12, dirT)));
        modelStep(mSec, 0, 59, enA, incA, dirA, ldA, int'(ldLsdA), int'(ldMsdA), nSec, wSec);
        modelStep(mMin, 0, 59, enA, incA && tSec, dirA, ldB, int'(ldLsdB), int'(ldMsdB), nMin, wMin);
        modelStep(mHr, 0, 23, enH, incH, dirH, ldH, int'(ldLsdH), int'(ldMsdH), nHr, wHr);
        modelStep(m12, 1, 12, enT, incT, dirT, ldT, int'(ldLsdT), int'(ldMsdT), n12, w12);
        @(negedge clock);
        checkOutput("sec_val",  int'({secMsd, secLsd}), toBcd(nSec));
        checkOutput("min_val",  int'({minMsd, minLsd}), toBcd(nMin));
        checkOutput("hr_val",   int'({hrMsd, hrLsd}),   toBcd(nHr));
        checkOutput("h12_val",  int'({tMsd, tLsd}),     toBcd(n12));
        checkOutput("sec_wrap", int'(secWrap), int'(wSec));
        checkOutput("min_wrap", int'(minWrap), int'(wMin));
        checkOutput("hr_wrap",  int'(hrWrap),  int'(wHr));
        checkOutput("h12_wrap", int'(tWrap),   int'(w12));
        mSec = nSec; mMin = nMin; mHr = nHr; m12 = n12;
    endtask

    initial begin
        vecs[0]  = '{1, 1, 0, 0, 0,  0, 1, 0};
        vecs[1]  = '{1, 0, 0, 0, 0,  0, 0, 0};
        vecs[2]  = '{1, 1, 0, 0, 0,  1, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 0,  1, 0, 0};
        vecs[4]  = '{1, 1, 1, 4, 7, 47, 0, 0};
        vecs[5]  = '{1, 0, 1, 5, 12, 59, 0, 1};
        vecs[6]  = '{1, 1, 0, 0, 0,  0, 1, 0};
        vecs[7]  = '{0, 0, 1, 7, 3, 59, 0, 1};
        vecs[8]  = '{0, 0, 1, 0, 0,  0, 0, 0};
        vecs[9]  = '{1, 0, 1, 5, 8, 58, 0, 0};
        vecs[10] = '{1, 1, 0, 0, 0, 59, 0, 1};
        vecs[11] = '{1, 1, 1, 5, 9, 59, 0, 1};
        vecs[12] = '{1, 1, 0, 0, 0,  0, 1, 0};
        vecs[13] = '{1, 0, 1, 0, 9,  9, 0, 0};
        vecs[14] = '{1, 1, 0, 0, 0, 10, 0, 0};

        setIdle();
        rstN = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("rst_sec_val",  int'({secMsd, secLsd}), toBcd(59));
        checkOutput("rst_sec_tc",   int'(secTc), 1);
        checkOutput("rst_sec_wrap", int'(secWrap), 0);
        checkOutput("rst_min_val",  int'({minMsd, minLsd}), toBcd(59));
        checkOutput("rst_hr_val",   int'({hrMsd, hrLsd}), toBcd(0));
        checkOutput("rst_hr_tc",    int'(hrTc), 0);
        checkOutput("rst_h12_val",  int'({tMsd, tLsd}), toBcd(12));
        checkOutput("rst_h12_tc",   int'(tTc), 1);
        rstN = 1'b1;
        resetModel();

        for (int i = 0; i < 15; i++) begin
            setIdle();
            enA = vecs[i].en; incA = vecs[i].inc; ldA = vecs[i].ld;
            ldMsdA = 3'(vecs[i].pMsd); ldLsdA = 4'(vecs[i].pLsd);
            applyStimulus();
            checkOutput("vec_val",  int'({secMsd, secLsd}), toBcd(vecs[i].expV));
            checkOutput("vec_wrap", int'(secWrap), int'(vecs[i].expWrap));
            checkOutput("vec_tc",   int'(secTc), int'(vecs[i].expTc));
        end

        for (int i = 0; i < 5; i++) begin
            setIdle(); enA = 1'b0; incA = 1'b1;
            applyStimulus();
            checkOutput("frozen_val", int'({secMsd, secLsd}), toBcd(10));
        end

        for (int i = 0; i < 24; i++) begin
            setIdle(); incH = 1'b1;
            applyStimulus();
            checkOutput("hr_seq",      int'({hrMsd, hrLsd}), toBcd((i + 1) % 24));
            checkOutput("hr_seq_wrap", int'(hrWrap), (i == 23) ? 1 : 0);
        end

        setIdle(); incT = 1'b1;
        applyStimulus();
        checkOutput("h12_tick", int'({tMsd, tLsd}), toBcd(1));
        checkOutput("h12_wrap_tick", int'(tWrap), 1);
        setIdle(); ldT = 1'b1; ldMsdT = 2'd1; ldLsdT = 4'd5;
        applyStimulus();
        checkOutput("h12_ld15", int'({tMsd, tLsd}), toBcd(12));
        setIdle(); ldT = 1'b1;
        applyStimulus();
        checkOutput("h12_ld00", int'({tMsd, tLsd}), toBcd(1));

`ifdef MAQB_DOWN_EN
        setIdle(); ldA = 1'b1;
        applyStimulus();
        setIdle(); dirA = 1'b1;
        #1;
        checkOutput("down_tc_at0", int'(secTc), 1);
        incA = 1'b1;
        applyStimulus();
        checkOutput("down_wrap_val", int'({secMsd, secLsd}), toBcd(59));
        checkOutput("down_wrap",     int'(secWrap), 1);
        checkOutput("down_tc_at59",  int'(secTc), 0);
        setIdle(); dirA = 1'b1; ldA = 1'b1; ldMsdA = 3'd1;
        applyStimulus();
        setIdle(); dirA = 1'b1; incA = 1'b1;
        applyStimulus();
        checkOutput("down_borrow", int'({secMsd, secLsd}), toBcd(9));
`else
        setIdle(); ldA = 1'b1; ldMsdA = 3'd1;
        applyStimulus();
        setIdle(); dirA = 1'b1; incA = 1'b1;
        applyStimulus();
        checkOutput("dir_ignored", int'({secMsd, secLsd}), toBcd(11));
        setIdle(); ldA = 1'b1; ldMsdA = 3'd5; ldLsdA = 4'd9;
        applyStimulus();
        setIdle(); dirA = 1'b1;
        #1;
        checkOutput("dir_ignored_tc", int'(secTc), 1);
`endif

        setIdle(); ldA = 1'b1; ldMsdA = 3'd5; ldLsdA = 4'd9;
        ldB = 1'b1; ldMsdB = 3'd5; ldLsdB = 4'd9;
        applyStimulus();
        setIdle(); incA = 1'b1;
        applyStimulus();
        checkOutput("casc_sec",      int'({secMsd, secLsd}), toBcd(0));
        checkOutput("casc_min",      int'({minMsd, minLsd}), toBcd(0));
        checkOutput("casc_min_wrap", int'(minWrap), 1);
        for (int i = 0; i < 3; i++) begin
            setIdle(); incA = 1'b1;
            applyStimulus();
        end
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("midrst_sec",  int'({secMsd, secLsd}), toBcd(59));
        checkOutput("midrst_min",  int'({minMsd, minLsd}), toBcd(59));
        checkOutput("midrst_wrap", int'(secWrap), 0);
        @(negedge clock);
        setIdle();
        rstN = 1'b1;
        resetModel();

        for (int i = 0; i < 400; i++) begin
            enA = ($urandom_range(0, 7) != 0); incA = ($urandom_range(0, 3) != 0);
            dirA = 1'($urandom_range(0, 1)); ldA = ($urandom_range(0, 9) == 0);
            ldB = ($urandom_range(0, 9) == 0);
            ldLsdA = 4'($urandom_range(0, 15)); ldMsdA = 3'($urandom_range(0, 7));
            ldLsdB = 4'($urandom_range(0, 15)); ldMsdB = 3'($urandom_range(0, 7));
            enH = ($urandom_range(0, 7) != 0); incH = 1'($urandom_range(0, 1));
            dirH = 1'($urandom_range(0, 1)); ldH = ($urandom_range(0, 9) == 0);
            ldLsdH = 4'($urandom_range(0, 15)); ldMsdH = 2'($urandom_range(0, 3));
            enT = ($urandom_range(0, 7) != 0); incT = 1'($urandom_range(0, 1));
            dirT = 1'($urandom_range(0, 1)); ldT = ($urandom_range(0, 9) == 0);
            ldLsdT = 4'($urandom_range(0, 15)); ldMsdT = 2'($urandom_range(0, 3));
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
